bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter placed directly upstream of the four-digit seven-segment display controller. Accepts an unsigned binary result from the calculator datapath on a one-cycle start strobe. Converts it to packed BCD with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock, and holds the last completed result stable for the display stage. Removes the divide/modulo chain from the display path so that stage becomes a pure digit multiplexer.

## Interface

Parameters:
- WIDTH, 13, binary input width in bits
- DIGITS, 4, number of BCD output digits

Ports:
- Clk  in  1  system clock; all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- start  in  1  conversion request; sampled only in IDLE
- number  in  WIDTH  unsigned binary value; sampled on the accepting edge only
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when bcd/overflow update
- bcd  out  4*DIGITS  packed result; bcd[4*DIGITS-1 -: 4] is the most significant digit
- overflow  out  1  last accepted number exceeded 10^DIGITS − 1

## Operation

- States: IDLE, SHIFT.
- IDLE:
  - start=1 → latch number into a WIDTH-bit shift register.
  - Clear the 4*DIGITS-bit BCD scratch register.
  - Load the iteration counter with WIDTH.
  - Compute ovf_pend = (number > 10^DIGITS − 1).
  - Go to SHIFT.
  - start=0 → remain in IDLE; outputs hold.
- SHIFT, one iteration per cycle:
  - Every scratch digit ≥ 5 gets +3 (all digits evaluated in parallel on pre-shift values).
  - Shift {scratch, binary} left by one.
  - Decrement the counter.
- Final iteration (counter reaches 1 before decrement):
  - If ovf_pend=0, bcd ← post-shift scratch and overflow ← 0.
  - If ovf_pend=1, every bcd digit ← 9 (saturate) and overflow ← 1.
  - done ← 1; return to IDLE.
- start while in SHIFT is ignored, not queued. number changes while in SHIFT have no effect.
- bcd/overflow change only on the done edge and retain their previous value during a conversion.
- Counter width is ceil(log2(WIDTH+1)) bits. Scratch digits never exceed 9 after correction. No carry is lost for in-range inputs.
- With default parameters the maximum input is 8191, so overflow is always 0. It is exercised by overriding WIDTH.

## Timing

- Reset (asynchronous, any state, including mid-conversion): state=IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0, scratch=0. An in-flight conversion is discarded and no done is produced.
- Start accepted at edge k:
  - busy=1 from after edge k until edge k+WIDTH.
  - done=1 and the new bcd/overflow are visible after edge k+WIDTH.
  - Latency is WIDTH cycles (13 by default).
- done is high for exactly one cycle. At that edge busy falls and state is IDLE.
- start=1 during the done cycle is accepted; it yields back-to-back conversions with throughput of one per WIDTH cycles.
- A start held high continuously causes a restart on every return to IDLE.
- busy is registered; no combinational path from start to any output.

## Test plan

- Reset, then start with number=1234 → busy high 13 cycles; done pulses at edge k+13; bcd=0x1234, overflow=0.
- Boundaries 0, 9, 10, 5009, 8191 → bcd 0x0000, 0x0009, 0x0010, 0x5009, 0x8191; each latency exactly 13.
- Start pulsed again at k+5 with number=42 during a 1234 conversion → ignored; result 0x1234; no extra done.
- Start asserted in the done cycle with number=777 → second done 13 cycles later; bcd=0x0777; previous 0x1234 holds in between.
- Rst asserted at k+6 during conversion of 4321, then released → all outputs zero; no done; a fresh start with 10 yields 0x0010.
- WIDTH=14: number=10000 → bcd=0x9999, overflow=1. Then 9999 → bcd=0x9999, overflow=0; latency 14.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Holds the last completed result for the downstream seven-segment mux.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    function automatic longint unsigned max_value();
        longint unsigned v;
        v = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    localparam longint unsigned MaxVal = max_value();

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  bin_q;
    logic [BcdW-1:0]   scratch_q;
    logic [CntW-1:0]   cnt_q;
    logic              ovf_pend_q;
    logic [BcdW-1:0]   corr;
    logic [BcdW-1:0]   shifted;

    // Add-3 correction on every digit in parallel, then shift in the next binary MSB.
    always_comb begin
        corr = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                corr[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = BcdW'({corr, bin_q[WIDTH-1]});
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bin_q      <= number;
                        scratch_q  <= '0;
                        cnt_q      <= CntW'(WIDTH);
                        ovf_pend_q <= (64'(number) > MaxVal);
                        busy       <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    scratch_q <= shifted;
                    bin_q     <= bin_q << 1;
                    cnt_q     <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        // Out-of-range inputs saturate the display to all nines.
                        bcd      <= ovf_pend_q ? {DIGITS{4'h9}} : shifted;
                        overflow <= ovf_pend_q;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: default (WIDTH=13) and WIDTH=14 instances against an arithmetic model.
module tb_bin_to_bcd_seq;

    logic        Clk;
    logic        Rst;
    logic        start;
    logic [13:0] num;

    logic        busy13, done13, ovf13;
    logic [15:0] bcd13;
    logic        busy14, done14, ovf14;
    logic [15:0] bcd14;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.WIDTH(13), .DIGITS(4)) dut13 (
        .Clk(Clk), .Rst(Rst), .start(start), .number(num[12:0]),
        .busy(busy13), .done(done13), .bcd(bcd13), .overflow(ovf13)
    );

    bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) dut14 (
        .Clk(Clk), .Rst(Rst), .start(start), .number(num),
        .busy(busy14), .done(done14), .bcd(bcd14), .overflow(ovf14)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: index 0 is WIDTH=13, index 1 is WIDTH=14.
    int          m_w[2] = '{13, 14};
    logic        m_busy[2];
    logic        m_done[2];
    logic        m_ovf[2];
    logic [15:0] m_bcd[2];
    int          m_rem[2];
    int unsigned m_val[2];

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_busy[j] = 1'b0;
            m_done[j] = 1'b0;
            m_ovf[j]  = 1'b0;
            m_bcd[j]  = '0;
            m_rem[j]  = 0;
            m_val[j]  = 0;
        end
    endtask

    task automatic model_update();
        if (Rst) begin
            model_reset();
            return;
        end
        for (int j = 0; j < 2; j++) begin
            m_done[j] = 1'b0;
            if (!m_busy[j]) begin
                if (start) begin
                    m_busy[j] = 1'b1;
                    m_rem[j]  = m_w[j];
                    m_val[j]  = (j == 0) ? int'(num[12:0]) : int'(num);
                end
            end else begin
                m_rem[j]--;
                if (m_rem[j] == 0) begin
                    m_busy[j] = 1'b0;
                    m_done[j] = 1'b1;
                    if (m_val[j] > 9999) begin
                        m_bcd[j] = 16'h9999;
                        m_ovf[j] = 1'b1;
                    end else begin
                        m_bcd[j] = to_bcd(m_val[j]);
                        m_ovf[j] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("busy13", 32'(busy13), 32'(m_busy[0]));
        chk("done13", 32'(done13), 32'(m_done[0]));
        chk("bcd13",  32'(bcd13),  32'(m_bcd[0]));
        chk("ovf13",  32'(ovf13),  32'(m_ovf[0]));
        chk("busy14", 32'(busy14), 32'(m_busy[1]));
        chk("done14", 32'(done14), 32'(m_done[1]));
        chk("bcd14",  32'(bcd14),  32'(m_bcd[1]));
        chk("ovf14",  32'(ovf14),  32'(m_ovf[1]));
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic wait_done(input int which, output int lat);
        logic got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            step();
            lat++;
            got = (which == 1) ? done14 : done13;
        end
        chk("done_timeout", 32'(got), 32'd1);
    endtask

    task automatic conv(input int unsigned n, input int which, input logic [15:0] exp_bcd,
                        input logic exp_ovf);
        int lat;
        start = 1'b1;
        num   = 14'(n);
        step();
        start = 1'b0;
        wait_done(which, lat);
        chk("latency", 32'(lat), (which == 1) ? 32'd14 : 32'd13);
        chk("bcd_lit", (which == 1) ? 32'(bcd14) : 32'(bcd13), 32'(exp_bcd));
        chk("ovf_lit", (which == 1) ? 32'(ovf14) : 32'(ovf13), 32'(exp_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int lat;
        int extra;
        Rst   = 1'b1;
        start = 1'b0;
        num   = '0;
        model_reset();

        chk("model_1234", 32'(to_bcd(1234)), 32'h1234);
        chk("model_5009", 32'(to_bcd(5009)), 32'h5009);
        chk("model_0",    32'(to_bcd(0)),    32'h0000);

        @(negedge Clk);
        compare_all();
        chk("rst_bcd", 32'(bcd13), 32'h0);
        chk("rst_busy", 32'(busy13), 32'h0);
        idle(2);
        Rst = 1'b0;
        idle(2);

        conv(1234, 0, 16'h1234, 1'b0);
        idle(2);
        conv(0,    0, 16'h0000, 1'b0); idle(2);
        conv(9,    0, 16'h0009, 1'b0); idle(2);
        conv(10,   0, 16'h0010, 1'b0); idle(2);
        conv(5009, 0, 16'h5009, 1'b0); idle(2);
        conv(8191, 0, 16'h8191, 1'b0); idle(2);

        // Start re-pulsed at k+5 must be ignored.
        start = 1'b1; num = 14'd1234;
        step();
        start = 1'b0;
        idle(4);
        start = 1'b1; num = 14'd42;
        step();
        start = 1'b0;
        wait_done(0, lat);
        chk("ignored_lat", 32'(lat), 32'd8);
        chk("ignored_bcd", 32'(bcd13), 32'h1234);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done13) extra++;
        end
        chk("no_extra_done", 32'(extra), 32'd0);

        // Back-to-back: start in the done cycle.
        conv(1234, 0, 16'h1234, 1'b0);
        start = 1'b1; num = 14'd777;
        step();
        start = 1'b0;
        chk("hold_prev", 32'(bcd13), 32'h1234);
        wait_done(0, lat);
        chk("b2b_lat", 32'(lat), 32'd13);
        chk("b2b_bcd", 32'(bcd13), 32'h0777);
        idle(3);

        // Asynchronous reset mid-conversion.
        start = 1'b1; num = 14'd4321;
        step();
        start = 1'b0;
        idle(5);
        Rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("midrst_busy", 32'(busy13), 32'd0);
        chk("midrst_bcd",  32'(bcd13),  32'h0);
        idle(2);
        Rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done13 || done14) extra++;
        end
        chk("rst_no_done", 32'(extra), 32'd0);
        conv(10, 0, 16'h0010, 1'b0);
        idle(3);

        // WIDTH=14 overflow saturation and the largest in-range value.
        conv(10000, 1, 16'h9999, 1'b1); idle(3);
        conv(9999,  1, 16'h9999, 1'b0); idle(3);

        // Randomized traffic, with held-start bursts and rare async resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                Rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                step();
                Rst = 1'b0;
            end
            if ((i / 500) % 2 == 1 && (i % 500) < 100) start = 1'b1;
            else start = ($urandom_range(0, 3) == 0);
            num = 14'($urandom_range(0, 16383));
            step();
        end
        start = 1'b0;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
